// File: rtl/dyser_cfg_loader.sv
// dyser_cfg_loader: streams one CFG_WORDS-long configuration image from a
//   synchronous config memory into the DySER config port.
// Latency: first config_en two cycles after start is accepted; done pulses
//   CFG_WORDS cycles after that. Backpressure: none. start is ignored while busy.
//   abort cancels a load in READ/LAST.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, abort_i      load request / cancel
//   base_addr_i           image start address, captured on accept
//   mem_rd_o, mem_addr_o  config-memory read strobe and address
//   mem_rdata_i           read data, valid one cycle after mem_rd_o
//   config_bits_o         config word (combinational copy of mem_rdata_i)
//   config_en_o           config_bits_o valid
//   busy_o, done_o        load in progress / one-cycle completion pulse
//   cfg_valid_o           a complete image is loaded
//   send_block_o          busy_o | ~cfg_valid_o
module dyser_cfg_loader #(
  parameter int CFG_WORDS  = 17,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [20:0]           mem_rdata_i,
  output logic [20:0]           config_bits_o,
  output logic                  config_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_valid_o,
  output logic                  send_block_o
);

  localparam int K_W = $clog2(CFG_WORDS + 1);
  // k_q holds the index of the word being read in the current READ cycle.
  localparam logic [K_W-1:0] K_LAST = K_W'(CFG_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic [K_W-1:0]          k_q;
  logic [K_W-1:0]          k_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic                    mem_rd_q;
  logic                    config_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    cfg_valid_q;

  assign k_d        = k_q + K_W'(1);
  // Natural overflow of the address register gives the modulo wrap.
  assign mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_q         <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      config_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      // Data returns one cycle after the read, so the enable simply trails
      // the read strobe; abort overrides it to drop the word in flight.
      config_en_q <= mem_rd_q;
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            state_q     <= READ;
            k_q         <= '0;
            mem_addr_q  <= base_addr_i;
            mem_rd_q    <= 1'b1;
            busy_q      <= 1'b1;
            cfg_valid_q <= 1'b0;
          end
        end
        READ: begin
          if (abort_i) begin
            state_q     <= IDLE;
            mem_rd_q    <= 1'b0;
            config_en_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (k_q == K_LAST) begin
            state_q  <= LAST;
            mem_rd_q <= 1'b0;
          end else begin
            k_q        <= k_d;
            mem_addr_q <= mem_addr_d;
          end
        end
        LAST: begin
          if (abort_i) begin
            state_q     <= IDLE;
            config_en_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            cfg_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // abort is deliberately not looked at here: the image is complete.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_o      = mem_rd_q;
  assign mem_addr_o    = mem_addr_q;
  assign config_bits_o = mem_rdata_i;
  assign config_en_o   = config_en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_valid_o   = cfg_valid_q;
  assign send_block_o  = busy_q | ~cfg_valid_q;

endmodule
